// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master side presents operands and accepts results; the slave side is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract through one 4-bit carry look-ahead slice, LSB nibble first.
// Latency: out_valid rises NIBBLES edges after accept; result is held while out_ready=0.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       s;
  logic             c1;
  logic             c2;
  logic             c3;
  logic             c4;
  logic [WIDTH-1:0] sum_nxt;

  // One look-ahead slice; carries are fully flattened from c0 = carry register.
  always_comb begin
    x  = a_q[{idx, 2'b00} +: 4];
    y  = b_q[{idx, 2'b00} +: 4];
    g  = x & y;
    p  = x | y;
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry);
    s  = x ^ y ^ {c3, c2, c1, carry};
    sum_nxt = sum_q;
    sum_nxt[{idx, 2'b00} +: 4] = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            // Subtract is folded into the operand so RUN only ever adds.
            b_q   <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub | bus.cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_nxt;
          carry <= c4;
          if (idx == LAST) begin
            cout_q <= c4;
            ovf_q  <= c3 ^ c4;
            zero_q <= ~|sum_nxt;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes reference results on accept,
// monitor pops and compares on each output handshake, checking latency and hold stability.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
  } stim_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();
  nibble_serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  stim_t stim_q[$];
  res_t  exp_q[$];
  int    acc_q[$];
  int    last_acc = -100;
  bit    gap_en = 1'b0;
  int    rdy_mode = 0;
  bit    mon_first = 1'b1;
  bit    rdy = 1'b0;
  res_t  held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result sign rules.
  function automatic res_t model(input stim_t s);
    res_t             r;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    bb   = s.op ? ~s.b : s.b;
    full = {1'b0, s.a} + {1'b0, bb} + ((s.op || s.cin) ? 17'd1 : 17'd0);
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    if (s.op) r.ovf = (s.a[WIDTH-1] != s.b[WIDTH-1]) && (r.sum[WIDTH-1] != s.a[WIDTH-1]);
    else      r.ovf = (s.a[WIDTH-1] == s.b[WIDTH-1]) && (r.sum[WIDTH-1] != s.a[WIDTH-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic op);
    stim_t s;
    s.a = a; s.b = b; s.cin = cin; s.op = op;
    stim_q.push_back(s);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_sum"},       32'(bus.sum),       32'd0);
    chk({tag, "_cout"},      32'(bus.cout),      32'd0);
    chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_pending"}, 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  // Driver: presents the queue head; an accept seen at the edge pushes the expected result.
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy) begin
        exp_q.push_back(model(stim_q[0]));
        acc_q.push_back(cyc);
        last_acc = cyc;
        void'(stim_q.pop_front());
      end
      if (stim_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b1;
        bus.a = stim_q[0].a; bus.b = stim_q[0].b;
        bus.cin = stim_q[0].cin; bus.op_sub = stim_q[0].op;
      end else begin
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
      end
      @(negedge clk);
      rdy = bus.in_valid && bus.in_ready && rst_n;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: ;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, one pop per completed output handshake.
  initial begin
    res_t cur;
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          cur = {bus.sum, bus.cout, bus.overflow, bus.zero};
          if (mon_first) begin
            chk("latency", 32'(cyc), 32'(acc_q[0] + NIB));
            held = cur;
            mon_first = 1'b0;
          end else begin
            chk("hold_stable", 32'(cur), 32'(held));
          end
          if (bus.out_ready) begin
            e = exp_q.pop_front();
            acc_q.delete(0);
            chk("sum",      32'(bus.sum),      32'(e.sum));
            chk("cout",     32'(bus.cout),     32'(e.cout));
            chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("zero",     32'(bus.zero),     32'(e.zero));
            mon_first = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int rel;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed arithmetic cases
    push(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    push(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b1, 1'b0);
    push(16'h8000, 16'h0001, 1'b0, 1'b1);
    push(16'h0003, 16'h0005, 1'b0, 1'b1);
    push(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    push(16'h0003, 16'h0005, 1'b1, 1'b1);
    wait_drain(300, "directed");

    // Backpressure with a second bundle waiting
    rdy_mode = 2;
    @(posedge clk); #2 bus.out_ready = 1'b0;
    push(16'hABCD, 16'h1111, 1'b1, 1'b0);
    push(16'h5555, 16'h0AAA, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #2; n++; end
    chk("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    rel = cyc;
    rdy_mode = 0;
    n = 0;
    while (stim_q.size() != 0 && n < 50) begin @(posedge clk); #2; n++; end
    chk("bp_accept_cycle", 32'(last_acc), 32'(rel + 2));
    wait_drain(100, "backpressure");

    // Reset during the second RUN cycle
    push(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() == 0 && n < 50) begin @(posedge clk); #3; n++; end
    chk("midrst_accepted", 32'(exp_q.size()), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    acc_q.delete();
    mon_first = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    push(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_drain(100, "after_reset");

    // Randomized traffic with input gaps and output stalls
    gap_en = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      push(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
    end
    wait_drain(40000, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
